// File: rtl/wb_grf_if.sv
// rtl/wb_grf_if.sv - W-stage writeback and D-stage read port bundle for wb_grf.
interface wb_grf_if;
  logic [31:0] IR_W;
  logic [31:0] PC8_W;
  logic [4:0]  A3_W;
  logic [31:0] AO_W;
  logic [31:0] DR_W;
  logic [2:0]  RES_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        WE_W;
  logic [31:0] retire_cnt;

  modport master (
    output IR_W, PC8_W, A3_W, AO_W, DR_W, RES_W, A1, A2,
    input  RD1, RD2, WD_W, WE_W, retire_cnt
  );

  modport slave (
    input  IR_W, PC8_W, A3_W, AO_W, DR_W, RES_W, A1, A2,
    output RD1, RD2, WD_W, WE_W, retire_cnt
  );
endinterface

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - writeback stage with 31x32 register file and retire counter.
// Optional write-through of WD_W onto the read ports: define WB_GRF_BYPASS_EN.
module wb_grf (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [31:0] regs [1:31];
  logic [31:0] retire_q;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1;
  logic [31:0] rd2;

  always_comb begin
    byte_sel = bus.DR_W[7:0];
    case (bus.AO_W[1:0])
      2'd1:    byte_sel = bus.DR_W[15:8];
      2'd2:    byte_sel = bus.DR_W[23:16];
      2'd3:    byte_sel = bus.DR_W[31:24];
      default: byte_sel = bus.DR_W[7:0];
    endcase
    half_sel = bus.AO_W[1] ? bus.DR_W[31:16] : bus.DR_W[15:0];
    case (bus.IR_W[31:26])
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = bus.DR_W;
    endcase
  end

  // Codes 4-7 behave like "none": no data and no write.
  always_comb begin
    wd = '0;
    we = 1'b0;
    case (bus.RES_W)
      3'd1:    wd = bus.AO_W;
      3'd2:    wd = load_data;
      3'd3:    wd = bus.PC8_W;
      default: wd = '0;
    endcase
    if ((bus.RES_W == 3'd1 || bus.RES_W == 3'd2 || bus.RES_W == 3'd3) && bus.A3_W != 5'd0)
      we = 1'b1;
  end

  assign bus.WD_W = wd;
  assign bus.WE_W = we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[bus.A3_W] <= wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retire_q <= '0;
    else if (|bus.IR_W)
      retire_q <= retire_q + 32'd1;
  end

  assign bus.retire_cnt = retire_q;

  always_comb begin
    rd1 = (bus.A1 == 5'd0) ? 32'd0 : regs[bus.A1];
    rd2 = (bus.A2 == 5'd0) ? 32'd0 : regs[bus.A2];
`ifdef WB_GRF_BYPASS_EN
    if (we && bus.A1 == bus.A3_W)
      rd1 = wd;
    if (we && bus.A2 == bus.A3_W)
      rd2 = wd;
`else
`endif
  end

  assign bus.RD1 = rd1;
  assign bus.RD2 = rd2;
endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low, and its port is named reset.
REQ-002 clk  input  1  rising-edge clock, shared with the pipeline registers.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 IR_W  input  32  instruction in W stage; 0 is a bubble.
REQ-005 PC8_W  input  32  PC+8 of the W instruction (link value).
REQ-006 A3_W  input  5  destination register number.
REQ-007 AO_W  input  32  ALU result / memory address.
REQ-008 DR_W  input  32  raw word read from data memory.
REQ-009 RES_W  input  3  result-source code: 0 none, 1 ALU, 2 DM, 3 PC8; codes 4-7 mean none.
REQ-010 A1  input  5  and A2  input  5: D-stage read addresses.
REQ-011 RD1  output  32  and RD2  output  32: read data.
REQ-012 WD_W  output  32  final write data, exported to the forwarding muxes.
REQ-013 WE_W  output  1  write enable actually applied this cycle.
REQ-014 retire_cnt  output  32  count of non-bubble instructions that left W.

Function
REQ-015 WE_W SHALL be 1 iff RES_W is in {1,2,3} and A3_W != 0.
REQ-016 WD_W SHALL select from the RES_W code: 1 -> AO_W; 2 -> load-extended DR_W; 3 -> PC8_W; any other code -> 0.
REQ-017 Load extension SHALL be decided by IR_W[31:26] and AO_W[1:0]:
- lb 0x20: sign-extend byte AO_W[1:0] (0 = bits 7:0 ... 3 = bits 31:24).
- lbu 0x24: zero-extend the same byte.
- lh 0x21: sign-extend half AO_W[1] (0 = bits 15:0, 1 = bits 31:16).
- lhu 0x25: zero-extend the same half.
- lw and any other opcode: DR_W unchanged.
REQ-018 The register file SHALL hold 31 x 32-bit registers ($1-$31); $0 SHALL always read 0 and SHALL ignore writes.
REQ-019 On the rising clk edge with WE_W=1, register[A3_W] SHALL take WD_W; the value SHALL be readable from the next cycle.
REQ-020 RD1 and RD2 SHALL be combinational from A1/A2 and the register contents, with zero read latency.
REQ-021 When A1 and A2 name the same register, both SHALL return identical data.
REQ-022 retire_cnt SHALL increment by 1 on each rising edge when IR_W != 0.
REQ-023 retire_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-024 A bubble (IR_W=0, RES_W=0) SHALL neither write the register file nor count.

Reset
REQ-025 While reset=0, all of $1-$31 SHALL read 0 and retire_cnt SHALL be 0, immediately and regardless of clk.
REQ-026 A write coinciding with reset assertion SHALL be lost.
REQ-027 After reset deasserts, the first rising edge SHALL operate normally.
REQ-028 WD_W and WE_W SHALL remain combinational from their inputs during reset.

Configuration
REQ-029 With macro WB_GRF_BYPASS_EN defined, if WE_W=1 and A1 (or A2) equals A3_W, RD1 (or RD2) SHALL return WD_W in the same cycle (write-through).
REQ-030 Without WB_GRF_BYPASS_EN, RD1 and RD2 SHALL return the stored value only; the external forwarding unit then covers the W-to-D hazard.

Verification
REQ-031 Reset scenario: assert reset=0 mid-cycle after writing $5=0x1234 -> RD1 with A1=5 reads 0 at once; retire_cnt=0.
REQ-032 ALU write and $0 guard: RES_W=1, A3_W=8, AO_W=0xDEADBEEF, one edge -> A1=8 reads 0xDEADBEEF. Repeat with A3_W=0 -> WE_W=0 and $0 still reads 0.
REQ-033 Load extension:
- lb, DR_W=0x80FF7F01, AO_W[1:0]=3 -> WD_W=0xFFFFFF80.
- lbu, same inputs -> 0x00000080.
- lh, AO_W[1]=0 -> 0x00007F01.
REQ-034 Link write: RES_W=3, A3_W=31, PC8_W=0x00003008 -> $31=0x00003008 after the edge.
REQ-035 Same-cycle hazard: WE_W=1, A3_W=A1=9, WD_W=0x55, $9 previously 0x11 -> RD1=0x55 with WB_GRF_BYPASS_EN defined, 0x11 without it; 0x55 after the edge in both builds.
REQ-036 Counter: preload 0xFFFFFFFE via 2 edges from a forced state (or count up), then apply 3 non-bubble cycles and 1 bubble -> retire_cnt = 0x00000001.
